adder_nibble_serial: RTL and testbench



---
 rtl/adder_nibble_serial_pkg.sv | 15 +
 rtl/adder_ripple4_struc2.sv | 21 ++
 rtl/adder_nibble_serial.sv | 94 +++++++++
 tb/tb_adder_nibble_serial.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/adder_nibble_serial_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM encodings
// and counter sizing helper.
package adder_nibble_serial_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int unsigned cnt_width(input int unsigned nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/adder_ripple4_struc2.sv
// 4-bit ripple-carry adder built from four gate-level full adders.
module adder_ripple4_struc2 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/adder_nibble_serial.sv
// Digit-serial WIDTH-bit adder: one 4-bit ripple slice reused NIB times with a
// registered carry, behind a valid/ready handshake on each side.
module adder_nibble_serial
  import adder_nibble_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NIB = WIDTH / NIBBLE_W;
  localparam int unsigned CW  = cnt_width(NIB);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("adder_nibble_serial: WIDTH must be a positive multiple of 4");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [3:0]       s_sum;
  logic             s_cout;

  adder_ripple4_struc2 u_slice (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout)
  );

  // Slice result enters at the top so nibble 0 ends up at the bottom after NIB shifts.
  assign acc_next = WIDTH'({s_sum, acc} >> NIBBLE_W);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            acc   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          a_sh  <= a_sh >> NIBBLE_W;
          b_sh  <= b_sh >> NIBBLE_W;
          carry <= s_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= acc_next;
            cout  <= s_cout;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_nibble_serial.sv
// Self-checking bench for adder_nibble_serial (WIDTH=16 and WIDTH=4 instances)
// against a plain-arithmetic reference sum.
module tb_adder_nibble_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, busy;
  logic [15:0] sum;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        in_ready4, out_valid4, cout4, busy4;
  logic [3:0]  sum4;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  adder_nibble_serial #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  adder_nibble_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=16 operation; bp = cycles of out_ready low after completion,
  // poke = drive junk operands with in_valid while busy.
  task automatic op16(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                      input int unsigned bp, input bit poke);
    logic [16:0] ref_full;
    int unsigned lat;
    ref_full = 17'(xa) + 17'(xb) + 17'(xc);
    @(negedge clk);
    a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = (bp == 0);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_run", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (poke) begin
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 32'd4);
    chk("sum", 32'(sum), 32'(ref_full[15:0]));
    chk("cout", 32'(cout), 32'(ref_full[16]));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    for (int unsigned i = 0; i < bp; i++) begin
      if (poke) begin
        a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
      end
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'({in_ready, cout, sum}), 32'({1'b0, ref_full}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("post_hs_state", 32'({out_valid, busy, in_ready}), 32'b001);
    chk("post_hs_hold", 32'({cout, sum}), 32'(ref_full));
  endtask

  task automatic op4(input logic [3:0] xa, input logic [3:0] xb, input logic xc);
    logic [4:0] ref_full;
    int unsigned lat;
    ref_full = 5'(xa) + 5'(xb) + 5'(xc);
    @(negedge clk);
    a4 = xa; b4 = xb; cin4 = xc; in_valid4 = 1'b1; out_ready4 = 1'b0;
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("w4_latency", lat, 32'd1);
    chk("w4_result", 32'({cout4, sum4}), 32'(ref_full));
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    chk("w4_idle", 32'({out_valid4, in_ready4}), 32'b01);
  endtask

  initial begin
    #3;
    chk("rst_outputs", 32'({out_valid, busy, cout, sum}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", 32'({in_ready, out_valid, busy}), 32'b100);

    op16(16'h0001, 16'h0001, 1'b0, 0, 1'b0);
    op16(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    op16(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
    op16(16'h00FF, 16'h0000, 1'b1, 0, 1'b0);
    op16(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
    op16(16'hBEEF, 16'h1111, 1'b0, 10, 1'b0);
    op16(16'h1357, 16'h2468, 1'b1, 2, 1'b1);

    // Reset two nibbles into a run; last result (nonzero) must vanish at once.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h1111; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_rst_outputs", 32'({out_valid, busy, cout, sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("midrun_rst_ready", 32'({in_ready, out_valid, busy}), 32'b100);
    op16(16'h0003, 16'h0004, 1'b0, 0, 1'b0);

    for (int i = 0; i < 20; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 2), 1'($urandom));

    op4(4'hF, 4'hF, 1'b1);
    for (int i = 0; i < 6; i++)
      op4(4'($urandom), 4'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
